sys_arr: RTL and testbench

- 4x4 output-stationary systolic array of IEEE-754 single-precision multiply-accumulate processing elements (PEs), used as the matrix-multiply core of the accelerator.
- Row operands (A) enter from the left edge and shift right one PE per cycle.
- Column operands (B) enter from the top edge and shift down one PE per cycle.
- Each PE accumulates its products in place, and all 16 accumulators are exposed as C = A·B.

---
 rtl/sys_arr.sv | 204 ++++++++++++++++++++
 tb/tb_sys_arr.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_arr.sv
// sys_arr: 4x4 output-stationary FP32 systolic MAC array.
// A shifts right, B shifts down, each PE accumulates C = A*B in place.

module sys_arr_pe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] acc
);

  localparam logic [31:0] QNAN = 32'h7fc00000;

  function automatic logic [31:0] fmul(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [47:0]        p;
    logic signed [10:0] e;
    logic               s;
    s = x[31] ^ y[31];
    if (&x[30:23] || &y[30:23]) return QNAN;
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 32'h0;
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = $signed({3'b000, x[30:23]})
      + $signed({3'b000, y[30:23]})
      - 11'sd127
      + $signed({10'd0, p[47]});
    if (e >= 11'sd255) return {s, 8'hff, 23'd0};
    if (e <= 11'sd0) return 32'h0;
    return {s, e[7:0], p[47] ? p[46:24] : p[45:23]};
  endfunction

  function automatic logic [31:0] fadd(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0]        g;
    logic [31:0]        l;
    logic [7:0]         d;
    logic [5:0]         sh;
    logic [5:0]         lz;
    logic [50:0]        mg;
    logic [50:0]        ml;
    logic [50:0]        mt;
    logic [50:0]        sum;
    logic               found;
    logic signed [10:0] e;
    logic               xn, yn, xi, yi;
    xn = &x[30:23] && |x[22:0];
    yn = &y[30:23] && |y[22:0];
    xi = &x[30:23] && ~|x[22:0];
    yi = &y[30:23] && ~|y[22:0];
    if (xn || yn) return QNAN;
    if (xi && yi) return (x[31] == y[31]) ? x : QNAN;
    if (xi) return x;
    if (yi) return y;
    if (x[30:23] == 8'd0) return (y[30:23] == 8'd0) ? 32'h0 : y;
    if (y[30:23] == 8'd0) return x;
    if (x[30:0] >= y[30:0]) begin
      g = x;
      l = y;
    end else begin
      g = y;
      l = x;
    end
    d  = g[30:23] - l[30:23];
    sh = (d > 8'd50) ? 6'd50 : d[5:0];
    mg = {2'b01, g[22:0], 26'd0};
    ml = {2'b01, l[22:0], 26'd0};
    mt = ml >> sh;
    // sticky bit keeps truncation exact when subtracting a shifted-out tail
    if ((mt << sh) != ml) mt[0] = 1'b1;
    sum = (g[31] == l[31]) ? mg + mt : mg - mt;
    if (sum == 51'd0) return 32'h0;
    lz    = 6'd0;
    found = 1'b0;
    for (int k = 50; k >= 0; k--) begin
      if (!found) begin
        if (sum[k]) found = 1'b1;
        else lz = lz + 6'd1;
      end
    end
    sum = sum << lz;
    e = $signed({3'b000, g[30:23]}) + 11'sd1
      - $signed({5'd0, lz});
    if (e >= 11'sd255) return {g[31], 8'hff, 23'd0};
    if (e <= 11'sd0) return 32'h0;
    return {g[31], e[7:0], sum[49:27]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc <= '0;
    else acc <= fadd(acc, fmul(a, b));
  end

endmodule

module sys_arr (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] l11,
  input  logic [31:0] l21,
  input  logic [31:0] l31,
  input  logic [31:0] l41,
  input  logic [31:0] u11,
  input  logic [31:0] u12,
  input  logic [31:0] u13,
  input  logic [31:0] u14,
  output logic [31:0] r11,
  output logic [31:0] r12,
  output logic [31:0] r13,
  output logic [31:0] r14,
  output logic [31:0] r21,
  output logic [31:0] r22,
  output logic [31:0] r23,
  output logic [31:0] r24,
  output logic [31:0] r31,
  output logic [31:0] r32,
  output logic [31:0] r33,
  output logic [31:0] r34,
  output logic [31:0] r41,
  output logic [31:0] r42,
  output logic [31:0] r43,
  output logic [31:0] r44
);

  logic [31:0] lin [4];
  logic [31:0] uin [4];
  logic [31:0] ain [4][4];
  logic [31:0] bin [4][4];
  logic [31:0] ap  [4][3];
  logic [31:0] bp  [3][4];
  logic [31:0] acc [4][4];

  assign lin[0] = l11;
  assign lin[1] = l21;
  assign lin[2] = l31;
  assign lin[3] = l41;
  assign uin[0] = u11;
  assign uin[1] = u12;
  assign uin[2] = u13;
  assign uin[3] = u14;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ain[i][0] = lin[i];
      bin[0][i] = uin[i];
      for (int j = 1; j < 4; j++) begin
        ain[i][j] = ap[i][j-1];
        bin[j][i] = bp[j-1][i];
      end
    end
  end

  // last column/row pass values leave the array, so no register for them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 3; j++) begin
          ap[i][j] <= '0;
          bp[j][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 3; j++) begin
          ap[i][j] <= ain[i][j];
          bp[j][i] <= bin[j][i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < 4; gj++) begin : g_col
      sys_arr_pe u_pe (
        .clk (clk),
        .rst (rst),
        .a   (ain[gi][gj]),
        .b   (bin[gi][gj]),
        .acc (acc[gi][gj])
      );
    end
  end

  assign r11 = acc[0][0];
  assign r12 = acc[0][1];
  assign r13 = acc[0][2];
  assign r14 = acc[0][3];
  assign r21 = acc[1][0];
  assign r22 = acc[1][1];
  assign r23 = acc[1][2];
  assign r24 = acc[1][3];
  assign r31 = acc[2][0];
  assign r32 = acc[2][1];
  assign r33 = acc[2][2];
  assign r34 = acc[2][3];
  assign r41 = acc[3][0];
  assign r42 = acc[3][1];
  assign r43 = acc[3][2];
  assign r44 = acc[3][3];

endmodule

// File: tb/tb_sys_arr.sv
// tb_sys_arr: randomized bench for sys_arr against a
// delay-line + real-arithmetic model of the array.

module tb_sys_arr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] lv [4];
  logic [31:0] uv [4];
  logic [31:0] l11, l21, l31, l41, u11, u12, u13, u14;
  logic [31:0] r11, r12, r13, r14, r21, r22, r23, r24;
  logic [31:0] r31, r32, r33, r34, r41, r42, r43, r44;
  logic [31:0] rv   [4][4];
  logic [31:0] lh   [4][4];
  logic [31:0] uh   [4][4];
  logic [31:0] macc [4][4];
  logic [31:0] ma   [4][4];
  logic [31:0] mb   [4][4];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign l11 = lv[0];
  assign l21 = lv[1];
  assign l31 = lv[2];
  assign l41 = lv[3];
  assign u11 = uv[0];
  assign u12 = uv[1];
  assign u13 = uv[2];
  assign u14 = uv[3];
  assign rv[0][0] = r11;
  assign rv[0][1] = r12;
  assign rv[0][2] = r13;
  assign rv[0][3] = r14;
  assign rv[1][0] = r21;
  assign rv[1][1] = r22;
  assign rv[1][2] = r23;
  assign rv[1][3] = r24;
  assign rv[2][0] = r31;
  assign rv[2][1] = r32;
  assign rv[2][2] = r33;
  assign rv[2][3] = r34;
  assign rv[3][0] = r41;
  assign rv[3][1] = r42;
  assign rv[3][2] = r43;
  assign rv[3][3] = r44;

  sys_arr dut (
    .clk(clk), .rst(rst),
    .l11(l11), .l21(l21), .l31(l31), .l41(l41),
    .u11(u11), .u12(u12), .u13(u13), .u14(u14),
    .r11(r11), .r12(r12), .r13(r13), .r14(r14),
    .r21(r21), .r22(r22), .r23(r23), .r24(r24),
    .r31(r31), .r32(r32), .r33(r33), .r34(r34),
    .r41(r41), .r42(r42), .r43(r43), .r44(r44)
  );

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // real -> FP32 with truncation, flush-to-zero and overflow to Inf
  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    int e;
    if (v == 0.0) return 32'h0;
    d = $realtobits(v);
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    if (e <= 0) return 32'h0;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic isnan(input logic [31:0] x);
    return &x[30:23] && |x[22:0];
  endfunction

  function automatic logic isinf(input logic [31:0] x);
    return &x[30:23] && ~|x[22:0];
  endfunction

  function automatic logic [31:0] m_mul(
    input logic [31:0] x,
    input logic [31:0] y
  );
    if (&x[30:23] || &y[30:23]) return 32'h7fc00000;
    return r2f(f2r(x) * f2r(y));
  endfunction

  function automatic logic [31:0] m_add(
    input logic [31:0] x,
    input logic [31:0] y
  );
    if (isnan(x) || isnan(y)) return 32'h7fc00000;
    if (isinf(x) && isinf(y))
      return (x[31] == y[31]) ? x : 32'h7fc00000;
    if (isinf(x)) return x;
    if (isinf(y)) return y;
    return r2f(f2r(x) + f2r(y));
  endfunction

  // row i input reaches column j after j edges; column j reaches row i after i
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          lh[i][j]   = 32'h0;
          uh[i][j]   = 32'h0;
          macc[i][j] = 32'h0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int d = 3; d > 0; d--) begin
          lh[i][d] = lh[i][d-1];
          uh[i][d] = uh[i][d-1];
        end
        lh[i][0] = lv[i];
        uh[i][0] = uv[i];
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          macc[i][j] = m_add(macc[i][j], m_mul(lh[i][j], uh[j][i]));
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        tests++;
        if (rv[i][j] !== macc[i][j]) begin
          fails++;
          $display("FAIL model r%0d%0d got %h want %h at %0t",
                   i + 1, j + 1, rv[i][j], macc[i][j], $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero();
    for (int k = 0; k < 4; k++) begin
      lv[k] = 32'h0;
      uv[k] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    zero();
    step();
    step();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rsmall();
    int k;
    k = int'($urandom_range(32, 0)) - 16;
    return r2f(k * 0.5);
  endfunction

  task automatic rand_all();
    for (int k = 0; k < 4; k++) begin
      lv[k] = rsmall();
      uv[k] = rsmall();
    end
  endtask

  task automatic feed_skew();
    for (int c = 0; c < 7; c++) begin
      for (int k = 0; k < 4; k++) begin
        lv[k] = 32'h0;
        uv[k] = 32'h0;
        if (c >= k && c - k < 4) begin
          lv[k] = ma[k][c-k];
          uv[k] = mb[c-k][k];
        end
      end
      step();
    end
    zero();
  endtask

  task automatic one_mac(input string nm, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    do_reset();
    lv[0] = a;
    uv[0] = b;
    step();
    zero();
    step();
    chk(nm, rv[0][0], exp);
  endtask

  initial begin
    zero();
    step();
    step();
    rst = 1'b1;

    chk("pin_mul", m_mul(32'hbfc00000, 32'h40000000), 32'hc0400000);
    chk("pin_rtz", m_add(32'h3f800000, 32'h34400000), 32'h3f800001);
    chk("pin_add", m_add(m_mul(32'h3f800000, 32'h3f800000),
                         32'h40400000), 32'h40800000);

    repeat (5) begin
      rand_all();
      step();
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("rst_clear", rv[i][j], 32'h0);
    zero();
    step();
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("rst_hold", rv[i][j], 32'h0);

    do_reset();
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      lv[k] = 32'h3f800000;
      uv[k] = 32'h3f800000;
    end
    step();
    zero();
    repeat (8) step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("ident", rv[i][j], (i == j) ? 32'h3f800000 : 32'h0);

    do_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 32'h3f800000;
        mb[i][j] = 32'h3f800000;
      end
    feed_skew();
    repeat (5) step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("ones", rv[i][j], 32'h40800000);

    do_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = r2f(real'(4 * i + j + 1));
        mb[i][j] = (i == j) ? 32'h3f800000 : 32'h0;
      end
    feed_skew();
    repeat (5) step();
    chk("gen_r12", rv[0][1], 32'h40000000);
    chk("gen_r14", rv[0][3], 32'h40800000);
    chk("gen_r21", rv[1][0], 32'h40a00000);
    chk("gen_r44", rv[3][3], 32'h41800000);

    do_reset();
    lv[1] = 32'h40000000;
    uv[2] = 32'h40400000;
    step();
    zero();
    repeat (8) step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("pass_apart", rv[i][j], 32'h0);

    do_reset();
    lv[1] = 32'h40000000;
    step();
    zero();
    uv[2] = 32'h40400000;
    step();
    zero();
    repeat (6) step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk("pass_meet", rv[i][j],
            (i == 1 && j == 2) ? 32'h40c00000 : 32'h0);

    one_mac("subnormal", 32'h00000001, 32'h3f800000, 32'h0);
    one_mac("inf_in", 32'h7f800000, 32'h3f800000, 32'h7fc00000);
    one_mac("overflow", 32'h7f000000, 32'h40000000, 32'h7f800000);
    one_mac("neg", 32'hbfc00000, 32'h40000000, 32'hc0400000);
    one_mac("underflow", 32'h3f000000, 32'h00800000, 32'h0);
    one_mac("minnorm", 32'h3f800000, 32'h00800000, 32'h00800000);

    do_reset();
    lv[0] = 32'h3f800000;
    uv[0] = 32'h3f800000;
    step();
    lv[0] = 32'h34400000;
    step();
    zero();
    step();
    chk("rtz", rv[0][0], 32'h3f800001);

    do_reset();
    lv[0] = 32'h3f800000;
    uv[0] = 32'h3f800000;
    step();
    lv[0] = 32'hbf800000;
    step();
    zero();
    step();
    chk("cancel", rv[0][0], 32'h0);

    do_reset();
    repeat (200) begin
      rand_all();
      step();
    end
    zero();
    repeat (6) step();

    repeat (20) begin
      do_reset();
      for (int k = 0; k < 4; k++) begin
        lv[k] = $urandom;
        uv[k] = $urandom;
      end
      step();
      zero();
      repeat (6) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
